// File: rtl/div_sched_if.sv
// Request, response and divider-side signal bundle for div_sched.
// The slave modport is the scheduler's view; the master modport is the clients plus divider.
interface div_sched_if #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_sign;
  logic [N_REQ*DATA_W-1:0] req_dividend;
  logic [N_REQ*DATA_W-1:0] req_divisor;

  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_quotient;
  logic [DATA_W-1:0]       rsp_remainder;
  logic                    rsp_dbz;

  logic                    div_en;
  logic                    div_sign;
  logic [DATA_W-1:0]       div_dividend;
  logic [DATA_W-1:0]       div_divisor;
  logic                    div_done;
  logic [DATA_W-1:0]       div_quotient;
  logic [DATA_W-1:0]       div_remainder;

  modport master (
    output req_valid, req_sign, req_dividend, req_divisor, rsp_ready,
           div_done, div_quotient, div_remainder,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz,
           div_en, div_sign, div_dividend, div_divisor
  );

  modport slave (
    input  req_valid, req_sign, req_dividend, req_divisor, rsp_ready,
           div_done, div_quotient, div_remainder,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz,
           div_en, div_sign, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one sequential divider among N_REQ requesters.
// Divide-by-zero is answered directly without starting the divider.
module div_sched #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
) (
  input  logic        clk,
  input  logic        rst,
  div_sched_if.slave  dif,
  output logic        busy
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr_q, gnt_q, pick;
  logic              any_req, accept, req_dbz;
  logic              sign_q, dbz_q;
  logic [DATA_W-1:0] dividend_q, divisor_q, quo_q, rem_q;
  logic [DATA_W-1:0] req_a, req_b;
  logic              req_s;
  logic [N_REQ-1:0]  gnt_oh;

  // First set index searching upward from p+1, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    logic            found;
    sel   = p;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(p) + k) % N_REQ);
      if (!found && v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign any_req = |dif.req_valid;
  assign pick    = rr_pick(dif.req_valid, ptr_q);
  assign req_a   = dif.req_dividend[int'(pick)*DATA_W +: DATA_W];
  assign req_b   = dif.req_divisor[int'(pick)*DATA_W +: DATA_W];
  assign req_s   = dif.req_sign[pick];
  assign req_dbz = (req_b == '0);
  assign gnt_oh  = onehot(gnt_q);

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    dif.req_ready = '0;
    case (state)
      IDLE: begin
        if (any_req && !rst) begin
          accept        = 1'b1;
          dif.req_ready = onehot(pick);
          state_nxt     = req_dbz ? RESP : RUN;
        end
      end
      RUN: begin
        if (dif.div_done) state_nxt = RESP;
      end
      RESP: begin
        if (|(dif.rsp_ready & gnt_oh)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Accept stage: latch operands; capture stage: latch divider results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= ID_W'(N_REQ - 1);
      gnt_q      <= '0;
      sign_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q      <= pick;
        gnt_q      <= pick;
        sign_q     <= req_s;
        dividend_q <= req_a;
        divisor_q  <= req_b;
        dbz_q      <= req_dbz;
        if (req_dbz) begin
          quo_q <= '1;
          rem_q <= req_a;
        end
      end
      if (state == RUN && dif.div_done) begin
        quo_q <= dif.div_quotient;
        rem_q <= dif.div_remainder;
      end
    end
  end

  assign dif.div_en        = (state == RUN);
  assign dif.div_sign      = sign_q;
  assign dif.div_dividend  = dividend_q;
  assign dif.div_divisor   = divisor_q;
  assign dif.rsp_valid     = (state == RESP) ? gnt_oh : '0;
  assign dif.rsp_quotient  = quo_q;
  assign dif.rsp_remainder = rem_q;
  assign dif.rsp_dbz       = dbz_q;
  assign busy              = (state != IDLE);
endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a behavioural subtract-shift divider timing model.
module tb_div_sched;
  localparam int DATA_W = 32;
  localparam int N_REQ  = 4;
  localparam int LAT    = DATA_W + 5;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  div_sched_if #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dif ();

  div_sched #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave),
    .busy(busy)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Divider model: done during the (DATA_W+4)th enabled cycle, garbage otherwise.
  logic [7:0] dcnt;
  always @(posedge clk) begin
    if (!dif.div_en) dcnt <= 8'd0;
    else             dcnt <= dcnt + 8'd1;
  end

  always_comb begin
    logic dn;
    dn                = dif.div_en && (dcnt == 8'(DATA_W + 3));
    dif.div_done      = dn;
    dif.div_quotient  = 32'hDEADBEEF;
    dif.div_remainder = 32'hDEADBEEF;
    if (dn && dif.div_divisor != '0) begin
      if (dif.div_sign) begin
        dif.div_quotient  = $signed(dif.div_dividend) / $signed(dif.div_divisor);
        dif.div_remainder = $signed(dif.div_dividend) % $signed(dif.div_divisor);
      end else begin
        dif.div_quotient  = dif.div_dividend / dif.div_divisor;
        dif.div_remainder = dif.div_dividend % dif.div_divisor;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_REQ-1:0] oh(input int i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = N_REQ - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Response monitor: pop and compare on every completed response handshake.
  always @(negedge clk) begin
    if (!rst && (dif.rsp_valid & dif.rsp_ready) != '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", dif.rsp_valid, oh(e.id));
        chk("rsp_quotient", dif.rsp_quotient, e.q);
        chk("rsp_remainder", dif.rsp_remainder, e.r);
        chk("rsp_dbz", dif.rsp_dbz, e.dbz);
      end
    end
  end

  task automatic issue(input int id, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    dif.req_sign[id]                       = s;
    dif.req_dividend[id*DATA_W +: DATA_W]  = a;
    dif.req_divisor[id*DATA_W +: DATA_W]   = b;
    dif.req_valid[id]                      = 1'b1;
    @(negedge clk);
    chk("req_ready_grant", dif.req_ready, oh(id));
    @(posedge clk); #1;
    dif.req_valid[id] = 1'b0;
  endtask

  // Entered in cycle 1 after acceptance; returns in the first rsp_valid cycle.
  task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_en,
                          input logic exp_sign);
    int   lat;
    logic sign_bad;
    lat      = 1;
    sign_bad = 1'b0;
    chk({tag, "_div_en_c1"}, dif.div_en, exp_en);
    while (dif.rsp_valid == '0 && lat < 200) begin
      if (dif.div_en && dif.div_sign !== exp_sign) sign_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_div_sign"}, sign_bad, 0);
  endtask

  int   rr_q[N_REQ] = '{333, 259, 214, 185};
  int   rr_r[N_REQ] = '{1, 1, 4, 1};
  int   gcnt[N_REQ];
  int   k;
  int   g;
  logic [N_REQ-1:0] drop;
  logic stale;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    dif.req_valid    = '1;
    dif.req_sign     = '0;
    dif.req_dividend = '0;
    dif.req_divisor  = '0;
    dif.rsp_ready    = '1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", dif.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_en", dif.div_en, 0);
    chk("rst_div_sign", dif.div_sign, 0);
    chk("rst_rsp_valid", dif.rsp_valid, 0);
    chk("rst_rsp_dbz", dif.rsp_dbz, 0);
    chk("rst_div_dividend", dif.div_dividend, 0);
    chk("rst_rsp_quotient", dif.rsp_quotient, 0);
    dif.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    sb.push_back('{0, 32'd14, 32'd2, 1'b0});
    issue(0, 1'b0, 32'd100, 32'd7);
    wait_rsp("udiv", LAT, 1'b1, 1'b0);

    sb.push_back('{2, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0});
    issue(2, 1'b1, 32'hFFFFFF9C, 32'd7);
    wait_rsp("sdiv", LAT, 1'b1, 1'b1);

    sb.push_back('{1, 32'hFFFFFFFF, 32'h1234, 1'b1});
    issue(1, 1'b0, 32'h1234, 32'd0);
    wait_rsp("dbz", 1, 1'b0, 1'b0);

    dif.rsp_ready[0] = 1'b0;
    sb.push_back('{0, 32'd100, 32'd0, 1'b0});
    issue(0, 1'b0, 32'd1000, 32'd10);
    wait_rsp("bp", LAT, 1'b1, 1'b0);
    dif.req_dividend[1*DATA_W +: DATA_W] = 32'd9;
    dif.req_divisor[1*DATA_W +: DATA_W]  = 32'd3;
    dif.req_valid[1]                     = 1'b1;
    repeat (10) begin
      chk("bp_rsp_valid", dif.rsp_valid, 4'b0001);
      chk("bp_quotient", dif.rsp_quotient, 32'd100);
      chk("bp_req_ready", dif.req_ready, 0);
      chk("bp_div_en", dif.div_en, 0);
      @(posedge clk); #1;
    end
    dif.req_valid[1] = 1'b0;
    dif.rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after_release", busy, 0);

    sb.push_back('{3, 32'd9, 32'd0, 1'b0});
    issue(3, 1'b0, 32'd81, 32'd9);
    wait_rsp("req3", LAT, 1'b1, 1'b0);

    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N_REQ; i++)
        sb.push_back('{i, 32'(rr_q[i]), 32'(rr_r[i]), 1'b0});
    @(posedge clk); #1;
    for (int i = 0; i < N_REQ; i++) begin
      dif.req_sign[i]                      = 1'b0;
      dif.req_dividend[i*DATA_W +: DATA_W] = 32'(1000 + 37 * i);
      dif.req_divisor[i*DATA_W +: DATA_W]  = 32'(i + 3);
      gcnt[i]                              = 0;
    end
    dif.req_valid = '1;
    k = 0;
    for (int cyc = 0; cyc < 2000 && !(k == 8 && sb.size() == 0); cyc++) begin
      @(negedge clk);
      drop = '0;
      if ((dif.req_ready & dif.req_valid) != '0) begin
        g = idx_of(dif.req_ready & dif.req_valid);
        chk("rr_grant", g, k % N_REQ);
        k++;
        gcnt[g]++;
        if (gcnt[g] == 2) drop[g] = 1'b1;
      end
      @(posedge clk); #1;
      dif.req_valid = dif.req_valid & ~drop;
    end
    chk("rr_accepts", k, 8);
    chk("rr_drained", sb.size(), 0);
    dif.req_valid = '0;

    issue(0, 1'b0, 32'd77, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("mid_div_en", dif.div_en, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", dif.rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    stale = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (dif.rsp_valid != '0) stale = 1'b1;
    end
    chk("mid_no_rsp", stale, 0);

    sb.push_back('{3, 32'd10, 32'd0, 1'b0});
    issue(3, 1'b0, 32'd50, 32'd5);
    wait_rsp("post_rst", LAT, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
